ocra_multi_dac_iface: RTL and testbench
=======================================

Name: ocra_multi_dac_iface

Overview:
Parametrised successor to the four-channel OCRA1 DAC serialiser. It accepts 32-bit command words, stages per-channel DAC words, and on a commit runs one shared SPI frame to N_CH DACs in parallel. The interface uses a common SCLK/SYNCn and one SDO line per channel, followed by an optional LDACn pulse. It sits between the gradient sequencer FIFO and the gradient board pins, and serves OCRA1 (4 channels) and wider boards (up to 8 channels).

Parameters:
N_CH, 4, number of DAC channels (1..8)
WORD_W, 24, bits per SPI word (8..24), taken from data_i[WORD_W-1:0], shifted MSB first
LDAC_CYC, 2, LDACn low duration in clk cycles (>=1)

Ports:
clk  in  1  system clock (125 MHz)
rst  in  1  asynchronous active-high reset
data_i  in  32  command word: [23:0] DAC word, [24] commit, [27:25] channel, [28] ldac_en, [31:29] reserved (ignored)
valid_i  in  1  data_i valid; accepted every cycle it is high
spi_clk_div_i  in  6  SPI half-period = spi_clk_div_i+1 clk cycles; sampled at frame start
oc_clk_o  out  1  SPI clock, idles high
oc_syncn_o  out  1  frame select, active low
oc_ldacn_o  out  1  DAC load strobe, active low
oc_sdo_o  out  N_CH  per-channel serial data
busy_o  out  1  frame or pending commit in progress
err_o  out  1  one-cycle pulse: channel field >= N_CH

Behaviour:
- Reset (async, rst=1):
  - oc_clk_o=1, oc_syncn_o=1, oc_ldacn_o=1, oc_sdo_o=0, busy_o=0, err_o=0.
  - Staging, shadow, pending and commit flags cleared; FSM goes to IDLE.
  - Reset during a frame aborts the frame immediately, with no further SCLK edges.
- Accept: on valid_i=1 with channel<N_CH, the staging register for that channel is loaded (last write wins) and its dirty bit is set.
- Channel >= N_CH: the word is dropped and err_o pulses the next cycle. The commit bit of a dropped word is ignored.
- Commit: the commit bit on an accepted word sets commit_pend and records ldac_en. The data in that same word is staged first.
- Frame start: in IDLE or at the end of GAP with commit_pend=1:
  - For each channel, the shadow register is loaded from staging if dirty, otherwise it keeps its previous value.
  - Dirty bits and commit_pend are cleared; the divider is latched.
  - Non-dirty channels resend their shadow word, so every DAC receives a word each frame. Shadow resets to 0.
- FSM, with H = div+1 clk cycles:
  - IDLE: all outputs at idle values.
  - SYNC (H): syncn=0, sclk=1, sdo=MSB.
  - SHIFT (WORD_W bits, 2H each): sclk=0 for H, then sclk=1 for H. sdo advances to the next bit on each sclk rise, so DACs sample on the falling edge.
  - END (H): sclk=1, syncn=0.
  - LDAC: syncn=1; if ldac_en, ldacn=0 for LDAC_CYC cycles, otherwise the state is skipped.
  - GAP (H): syncn=1. Then go to SYNC if commit_pend, else IDLE.
- Timing:
  - syncn falls 1 cycle after the accepted commit word.
  - Frame busy length = 2H + 2H*WORD_W + (ldac_en ? LDAC_CYC : 0) + H.
- busy_o: high from the cycle after an accepted commit through the last GAP cycle. It stays high continuously across back-to-back frames.
- Writes during a busy frame are staged and do not disturb the shifting words. A commit during a busy frame chains another frame.
- spi_clk_div_i changes mid-frame have no effect until the next frame.

Test Plan:
1. N_CH=4, div=0, ldac_en=1: write ch0..ch3 = 0x200002 with commit on ch3.
   -> syncn low for 50 cycles, 24 sclk falls per frame, each DAC model receives 0x200002, ldacn low 2 cycles, busy high 53 cycles.
2. Write ch1 only = 0x100004 with commit, after a frame loading 0x100008 on all channels.
   -> ch1 receives 0x100004; ch0, ch2, ch3 receive 0x100008 again.
3. Channel field 5 with N_CH=4.
   -> err_o one-cycle pulse, no frame started, busy_o stays 0.
4. Commit a new set mid-frame (div=3).
   -> first frame completes unchanged; second frame's SYNC follows GAP directly; busy_o never drops between frames.
5. ldac_en=0 commit.
   -> ldacn stays 1; busy length = 2H+48H+H.
6. Assert rst during SHIFT bit 10.
   -> all outputs idle in the same cycle; no further sclk edges; the next commit frame resends zero shadows on non-dirty channels.

Source files
------------

// File: rtl/ocra_multi_dac_iface.sv
// Shared-frame SPI serialiser for N_CH gradient DACs: stages per-channel words,
// then on commit shifts every channel's shadow word out in one common SCLK/SYNCn frame.
module ocra_multi_dac_iface #(
  parameter int N_CH     = 4,
  parameter int WORD_W   = 24,
  parameter int LDAC_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     data_i,
  input  logic            valid_i,
  input  logic [5:0]      spi_clk_div_i,
  output logic            oc_clk_o,
  output logic            oc_syncn_o,
  output logic            oc_ldacn_o,
  output logic [N_CH-1:0] oc_sdo_o,
  output logic            busy_o,
  output logic            err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_SHIFT, ST_END, ST_LDAC, ST_GAP
  } state_t;

  state_t            state_r, state_s;
  logic [15:0]       cnt_r, cnt_s;
  logic [4:0]        bit_r, bit_s, idx_s;
  logic              hi_r, hi_s;
  logic [5:0]        div_r, div_s;
  logic              ldac_r, ldac_s;
  logic              pend_r, pend_s;
  logic              pend_ldac_r, pend_ldac_s;
  logic              start_s;
  logic [WORD_W-1:0] stage_r [N_CH];
  logic [WORD_W-1:0] stage_s [N_CH];
  logic [WORD_W-1:0] shadow_r [N_CH];
  logic [WORD_W-1:0] shadow_s [N_CH];
  logic [N_CH-1:0]   dirty_r, dirty_m_s, dirty_s;
  logic              sclk_s, syncn_s, ldacn_s, busy_s, err_s;
  logic [N_CH-1:0]   sdo_s;

  logic [2:0] ch_s;
  logic       ch_ok_s, accept_s, commit_s, go_s;
  logic       unused_bits_s;

  assign ch_s          = data_i[27:25];
  assign ch_ok_s       = ({1'b0, ch_s} < 4'(N_CH));
  assign accept_s      = valid_i & ch_ok_s;
  assign commit_s      = accept_s & data_i[24];
  assign go_s          = pend_r | commit_s;
  assign unused_bits_s = ^data_i[31:29];

  function automatic logic bit_at(input logic [WORD_W-1:0] word, input logic [4:0] idx);
    logic [WORD_W-1:0] sh;
    sh = word >> idx;
    return sh[0];
  endfunction

  // Merge the incoming word into staging so a commit word's own data is included
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      if (accept_s && (ch_s == 3'(c))) begin
        stage_s[c]   = data_i[WORD_W-1:0];
        dirty_m_s[c] = 1'b1;
      end else begin
        stage_s[c]   = stage_r[c];
        dirty_m_s[c] = dirty_r[c];
      end
    end
  end

  // Frame sequencing; each state lasts until cnt_r reaches zero
  always_comb begin
    state_s     = state_r;
    cnt_s       = (cnt_r != 16'd0) ? (cnt_r - 16'd1) : cnt_r;
    bit_s       = bit_r;
    hi_s        = hi_r;
    div_s       = div_r;
    ldac_s      = ldac_r;
    start_s     = 1'b0;
    pend_s      = pend_r | commit_s;
    pend_ldac_s = commit_s ? data_i[28] : pend_ldac_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) start_s = 1'b1;
        else      state_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_SHIFT;
          cnt_s   = {10'd0, div_r};
          hi_s    = 1'b0;
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_SHIFT: begin
        if (cnt_r != 16'd0) begin
          state_s = ST_SHIFT;
        end else if (!hi_r) begin
          hi_s  = 1'b1;
          cnt_s = {10'd0, div_r};
        end else if (bit_r == 5'd0) begin
          state_s = ST_END;
          cnt_s   = {10'd0, div_r};
        end else begin
          bit_s = bit_r - 5'd1;
          hi_s  = 1'b0;
          cnt_s = {10'd0, div_r};
        end
      end
      ST_END: begin
        if (cnt_r != 16'd0) begin
          state_s = ST_END;
        end else if (ldac_r) begin
          state_s = ST_LDAC;
          cnt_s   = 16'(LDAC_CYC - 1);
        end else begin
          state_s = ST_GAP;
          cnt_s   = {10'd0, div_r};
        end
      end
      ST_LDAC: begin
        if (cnt_r == 16'd0) begin
          state_s = ST_GAP;
          cnt_s   = {10'd0, div_r};
        end else begin
          state_s = ST_LDAC;
        end
      end
      ST_GAP: begin
        if (cnt_r != 16'd0) state_s = ST_GAP;
        else if (go_s)      start_s = 1'b1;
        else                state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
    if (start_s) begin
      state_s = ST_SYNC;
      cnt_s   = {10'd0, spi_clk_div_i};
      div_s   = spi_clk_div_i;
      bit_s   = 5'(WORD_W - 1);
      hi_s    = 1'b0;
      ldac_s  = commit_s ? data_i[28] : pend_ldac_r;
      pend_s  = 1'b0;
    end else begin
      pend_s  = pend_r | commit_s;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (start_s) shadow_s[c] = dirty_m_s[c] ? stage_s[c] : shadow_r[c];
      else         shadow_s[c] = shadow_r[c];
    end
    dirty_s = start_s ? {N_CH{1'b0}} : dirty_m_s;
  end

  // Next-cycle pin values; sdo moves to the following bit while sclk is high
  always_comb begin
    sclk_s  = !((state_s == ST_SHIFT) && !hi_s);
    syncn_s = !((state_s == ST_SYNC) || (state_s == ST_SHIFT) || (state_s == ST_END));
    ldacn_s = (state_s != ST_LDAC);
    busy_s  = (state_s != ST_IDLE);
    err_s   = valid_i & ~ch_ok_s;
    idx_s   = ((state_s == ST_SHIFT) && hi_s) ? (bit_s - 5'd1) : bit_s;
    for (int c = 0; c < N_CH; c++) begin
      if ((state_s == ST_SYNC) || (state_s == ST_SHIFT)) sdo_s[c] = bit_at(shadow_s[c], idx_s);
      else                                              sdo_s[c] = 1'b0;
    end
  end

  // State, staging and registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      bit_r       <= 5'd0;
      hi_r        <= 1'b0;
      div_r       <= 6'd0;
      ldac_r      <= 1'b0;
      pend_r      <= 1'b0;
      pend_ldac_r <= 1'b0;
      dirty_r     <= {N_CH{1'b0}};
      for (int c = 0; c < N_CH; c++) begin
        stage_r[c]  <= {WORD_W{1'b0}};
        shadow_r[c] <= {WORD_W{1'b0}};
      end
      oc_clk_o    <= 1'b1;
      oc_syncn_o  <= 1'b1;
      oc_ldacn_o  <= 1'b1;
      oc_sdo_o    <= {N_CH{1'b0}};
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_r       <= bit_s;
      hi_r        <= hi_s;
      div_r       <= div_s;
      ldac_r      <= ldac_s;
      pend_r      <= pend_s;
      pend_ldac_r <= pend_ldac_s;
      dirty_r     <= dirty_s;
      for (int c = 0; c < N_CH; c++) begin
        stage_r[c]  <= stage_s[c];
        shadow_r[c] <= shadow_s[c];
      end
      oc_clk_o    <= sclk_s;
      oc_syncn_o  <= syncn_s;
      oc_ldacn_o  <= ldacn_s;
      oc_sdo_o    <= sdo_s;
      busy_o      <= busy_s;
      err_o       <= err_s;
    end
  end

endmodule

// File: tb/tb_ocra_multi_dac_iface.sv
// Directed + randomized bench for ocra_multi_dac_iface: per-channel DAC receivers
// decode the SPI frames and are compared with a word-level staging/shadow model.
module tb_ocra_multi_dac_iface;
  localparam int N_CH = 4;
  localparam int WW   = 24;
  localparam int LC   = 2;

  logic            clk, rst, valid_i;
  logic [31:0]     data_i;
  logic [5:0]      spi_clk_div_i;
  logic            oc_clk_o, oc_syncn_o, oc_ldacn_o, busy_o, err_o;
  logic [N_CH-1:0] oc_sdo_o;

  ocra_multi_dac_iface #(.N_CH(N_CH), .WORD_W(WW), .LDAC_CYC(LC)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
    .spi_clk_div_i(spi_clk_div_i), .oc_clk_o(oc_clk_o), .oc_syncn_o(oc_syncn_o),
    .oc_ldacn_o(oc_ldacn_o), .oc_sdo_o(oc_sdo_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int checks = 0, passed = 0, fails = 0;

  // DAC receivers: shift in sdo on every sclk fall while syncn is low
  logic [WW-1:0] acc [N_CH];
  logic [WW-1:0] rx_log [32][N_CH];
  int nbits = 0, falls = 0, sync_low = 0, ldac_low = 0, busy_cyc = 0;
  int busy_falls = 0, err_cyc = 0, frames = 0;
  logic prev_sclk = 1'b1, prev_sync = 1'b1, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!oc_syncn_o) sync_low++;
    if (!oc_ldacn_o) ldac_low++;
    if (busy_o) busy_cyc++;
    if (err_o) err_cyc++;
    if (prev_busy && !busy_o) busy_falls++;
    if (prev_sync && !oc_syncn_o) nbits = 0;
    if (prev_sclk && !oc_clk_o) begin
      falls++;
      if (!oc_syncn_o) begin
        for (int c = 0; c < N_CH; c++) acc[c] = {acc[c][WW-2:0], oc_sdo_o[c]};
        nbits++;
      end
    end
    if (!prev_sync && oc_syncn_o && !rst && nbits == WW && frames < 32) begin
      for (int c = 0; c < N_CH; c++) rx_log[frames][c] = acc[c];
      frames++;
    end
    prev_sclk = oc_clk_o;
    prev_sync = oc_syncn_o;
    prev_busy = busy_o;
  end

  // Word-level model: what each DAC must receive per committed frame
  logic [WW-1:0] m_stage [N_CH], m_shadow [N_CH];
  bit            m_dirty [N_CH];
  logic [WW-1:0] exp_log [32][N_CH];
  int exp_n = 0, chk_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_commit();
    for (int c = 0; c < N_CH; c++) begin
      if (m_dirty[c]) m_shadow[c] = m_stage[c];
      exp_log[exp_n][c] = m_shadow[c];
      m_dirty[c] = 1'b0;
    end
    exp_n++;
  endtask

  task automatic wr(input int ch, input logic [WW-1:0] w, input bit commit, input bit ldac);
    logic [2:0] chf;
    chf = ch[2:0];
    tick();
    data_i  = {3'($urandom), ldac, chf, commit, w};
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    data_i  = $urandom;
    if (ch < N_CH) begin
      m_stage[ch] = w;
      m_dirty[ch] = 1'b1;
      if (commit) model_commit();
    end
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy_o && k < max) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_frames();
    check("frame_count", frames, exp_n);
    while (chk_n < exp_n && chk_n < frames) begin
      for (int c = 0; c < N_CH; c++)
        check($sformatf("frame%0d_ch%0d", chk_n, c), 32'(rx_log[chk_n][c]), 32'(exp_log[chk_n][c]));
      chk_n++;
    end
  endtask

  int s0, f0, l0, b0, bf0, e0, fr0, h, ld, nw, k;
  logic [WW-1:0] w;

  initial begin
    rst = 1'b1; valid_i = 1'b0; data_i = 32'd0; spi_clk_div_i = 6'd0;
    for (int c = 0; c < N_CH; c++) begin
      m_stage[c] = '0; m_shadow[c] = '0; m_dirty[c] = 1'b0;
    end
    repeat (3) tick();
    check("rst_sclk", {31'd0, oc_clk_o}, 32'd1);
    check("rst_syncn", {31'd0, oc_syncn_o}, 32'd1);
    check("rst_ldacn", {31'd0, oc_ldacn_o}, 32'd1);
    check("rst_sdo", {28'd0, oc_sdo_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: all channels 0x200002, div 0, ldac on
    s0 = sync_low; f0 = falls; l0 = ldac_low; b0 = busy_cyc;
    for (int c = 0; c < N_CH; c++) wr(c, 24'h200002, c == N_CH - 1, 1'b1);
    check("t1_syncn_fell", {31'd0, oc_syncn_o}, 32'd0);
    wait_idle(300);
    check("t1_sync_low", sync_low - s0, 50);
    check("t1_falls", falls - f0, 24);
    check("t1_ldac_low", ldac_low - l0, 2);
    check("t1_busy_len", busy_cyc - b0, 53);
    check_frames();

    // 2: only ch1 updated; others resend their shadow
    for (int c = 0; c < N_CH; c++) wr(c, 24'h100008, c == N_CH - 1, 1'b1);
    wait_idle(300);
    wr(1, 24'h100004, 1'b1, 1'b1);
    wait_idle(300);
    check_frames();

    // 3: out-of-range channel is dropped with an error pulse
    b0 = busy_cyc; e0 = err_cyc; fr0 = frames;
    wr(5, 24'hABCDEF, 1'b1, 1'b1);
    repeat (5) tick();
    check("t3_err_pulses", err_cyc - e0, 1);
    check("t3_no_busy", busy_cyc - b0, 0);
    check("t3_no_frame", frames - fr0, 0);

    // 5 + random: random divider, ldac, channel subset and data
    for (int it = 0; it < 6; it++) begin
      h  = (it == 0) ? 1 : int'($urandom_range(1, 4));
      ld = (it == 0) ? 0 : int'($urandom_range(0, 1));
      nw = int'($urandom_range(1, 4));
      spi_clk_div_i = 6'(h - 1);
      s0 = sync_low; f0 = falls; l0 = ldac_low; b0 = busy_cyc;
      for (int i = 0; i < nw; i++) begin
        w = 24'($urandom);
        wr(int'($urandom_range(0, N_CH - 1)), w, i == nw - 1, ld[0]);
      end
      wait_idle(2000);
      check($sformatf("r%0d_busy_len", it), busy_cyc - b0, 51 * h + (ld != 0 ? LC : 0));
      check($sformatf("r%0d_sync_low", it), sync_low - s0, 50 * h);
      check($sformatf("r%0d_ldac_low", it), ldac_low - l0, ld != 0 ? LC : 0);
      check($sformatf("r%0d_falls", it), falls - f0, 24);
      check_frames();
    end

    // 4: chained commit mid-frame with div 3 and a transient div change
    spi_clk_div_i = 6'd3;
    b0 = busy_cyc; bf0 = busy_falls;
    for (int c = 0; c < N_CH; c++) wr(c, 24'($urandom), c == N_CH - 1, 1'b1);
    repeat (30) tick();
    spi_clk_div_i = 6'd0;
    repeat (10) tick();
    spi_clk_div_i = 6'd3;
    for (int c = 0; c < N_CH; c++) wr(c, 24'($urandom), c == N_CH - 1, 1'b1);
    wait_idle(2000);
    check("t4_busy_len", busy_cyc - b0, 2 * (51 * 4 + LC));
    check("t4_busy_falls", busy_falls - bf0, 1);
    check_frames();

    // 6: reset during SHIFT bit 10 aborts the frame; shadows return to zero
    spi_clk_div_i = 6'd0;
    f0 = falls;
    for (int c = 0; c < N_CH; c++) wr(c, 24'($urandom), c == N_CH - 1, 1'b1);
    k = 0;
    while (falls - f0 < 14 && k < 200) begin
      tick();
      k++;
    end
    check("t6_reach_bit10", falls - f0, 14);
    rst = 1'b1;
    #1;
    check("t6_sclk", {31'd0, oc_clk_o}, 32'd1);
    check("t6_syncn", {31'd0, oc_syncn_o}, 32'd1);
    check("t6_ldacn", {31'd0, oc_ldacn_o}, 32'd1);
    check("t6_sdo", {28'd0, oc_sdo_o}, 32'd0);
    check("t6_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) tick();
    f0 = falls;
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      m_stage[c] = '0; m_shadow[c] = '0; m_dirty[c] = 1'b0;
    end
    exp_n = frames; chk_n = frames;
    repeat (5) tick();
    check("t6_no_edges", falls - f0, 0);
    wr(2, 24'($urandom), 1'b1, 1'b0);
    wait_idle(300);
    check_frames();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
